// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
//
// Sequential restoring divider. It computes an unsigned quotient/remainder
// pair for i_dividend / i_divisor and produces one quotient bit per clock.
// Operands are accepted with a valid/ready handshake. The result is
// announced with a single-cycle strobe. A zero divisor is flagged with
// o_div_by_zero and returns an all-ones quotient without iterating.
//
// Parameters:
//   N  dividend / quotient width (N >= 2)
//   M  divisor / remainder width (1 <= M <= N)
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst           synchronous active-high reset
//   i_data_valid    operands valid, sampled only while o_div_ready = 1
//   i_dividend      unsigned dividend, N bits
//   i_divisor       unsigned divisor, M bits
//   o_quotient      registered quotient, N bits
//   o_remainder     registered remainder, M bits
//   o_result_valid  one-cycle strobe, result valid in that cycle
//   o_div_by_zero   registered flag, held with the result
//   o_div_ready     idle, can accept operands
// ---------------------------------------------------------------------------
module divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_data_valid,
  input  logic [N-1:0] i_dividend,
  input  logic [M-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [M-1:0] o_remainder,
  output logic         o_result_valid,
  output logic         o_div_by_zero,
  output logic         o_div_ready
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  count;
  logic [M:0]     pr;
  logic [N-1:0]   dq;
  logic [M-1:0]   divisor_q;

  logic           accept;
  logic           last_iter;
  logic [M:0]     pr_shift;
  logic [M:0]     pr_step;
  logic           q_bit;
  logic [N-1:0]   dq_step;

  assign accept    = i_data_valid & o_div_ready;
  assign last_iter = (count == CW'(N - 1));

  // One restoring step. The dividend MSB shifts into the partial remainder.
  // The compare/subtract is done at M+1 bits. The partial remainder stays
  // below the divisor, so the shifted value always fits.
  always_comb begin
    pr_shift = (pr << 1) | {{M{1'b0}}, dq[N-1]};
    q_bit    = (pr_shift >= {1'b0, divisor_q});
    pr_step  = q_bit ? (pr_shift - {1'b0, divisor_q}) : pr_shift;
    dq_step  = {dq[N-2:0], q_bit};
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (i_divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    o_div_ready    = 1'b0;
    o_result_valid = 1'b0;
    case (state)
      IDLE:    o_div_ready    = 1'b1;
      DONE:    o_result_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath and result registers. The operands are captured on accept, so
  // input changes while the block is busy cannot disturb the running division.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count         <= '0;
      pr            <= '0;
      dq            <= '0;
      divisor_q     <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (i_divisor == '0) begin
              o_quotient    <= '1;
              o_remainder   <= '0;
              o_div_by_zero <= 1'b1;
            end else begin
              pr        <= '0;
              dq        <= i_dividend;
              divisor_q <= i_divisor;
              count     <= '0;
            end
          end
        end
        CALC: begin
          pr    <= pr_step;
          dq    <= dq_step;
          count <= count + CW'(1);
          if (last_iter) begin
            o_quotient    <= dq_step;
            o_remainder   <= pr_step[M-1:0];
            o_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
